// File: rtl/seg_pkg.sv
// ============================================================================
// Module      : seg_pkg
// Description : Segment-vector type and active-low font constants shared by
//               the seven-segment scanner and its font decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

  // Segment vector ordered {g,f,e,d,c,b,a}; a 0 bit lights the segment.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b0000011;
  localparam seg_t SEG_C = 7'b1000110;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;

endpackage

`default_nettype wire

// File: rtl/seg_font_decode.sv
// ============================================================================
// Module      : seg_font_decode
// Description : Combinational nibble to active-low segment lookup.
//               Build option SEG_HEX_EN: defined renders 10-15 as A b C d E F,
//               undefined renders 10-15 blank (BCD-only display).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_font_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  // Font lookup; hex glyphs only exist when the hex build option is set.
  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
`ifdef SEG_HEX_EN
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
`else
      default: seg = SEG_BLANK;
`endif
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seven_segment_scanner.sv
// ============================================================================
// Module      : seven_segment_scanner
// Description : Time-multiplexed common-anode seven-segment driver with a
//               double-buffered value, per-digit enable, decimal points,
//               leading-zero blanking and an anti-ghosting blank interval.
//               Build option SEG_HEX_EN selects hex glyphs for 10-15.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_scanner
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   digit_en,
  input  logic                lz_blank,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [DIGITS-1:0]   an,
  output logic                frame_tick
);

  localparam int c_cnt_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DIGITS - 1);

  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_idx_w-1:0]  r_idx;
  logic [4*DIGITS-1:0] r_pend;
  logic [DIGITS-1:0]   r_pend_dp;
  logic [4*DIGITS-1:0] r_act;
  logic [DIGITS-1:0]   r_act_dp;
  logic                r_wrapped;

  logic                w_cnt_wrap;
  logic                w_frame_wrap;
  logic                w_in_blank;
  logic [3:0]          w_nib;
  logic                w_en;
  logic                w_act_dp;
  logic                w_lz;
  logic [DIGITS-1:0]   w_an_sel;
  logic                w_run;
  seg_t                w_font;

  assign w_cnt_wrap   = (r_cnt == c_last_cnt);
  assign w_frame_wrap = w_cnt_wrap && (r_idx == c_last_idx);

  // Anti-ghosting window at the start of each slot; absent when zero-length.
  generate
    if (BLANK_CYCLES == 0) begin : g_blank_none
      assign w_in_blank = 1'b0;
    end else begin : g_blank_win
      assign w_in_blank = (r_cnt < c_cnt_w'(BLANK_CYCLES));
    end
  endgenerate

  // Slot counter and digit index; the index wrap marks the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_wrapped <= 1'b0;
    end else begin
      r_wrapped <= w_frame_wrap;
      if (w_cnt_wrap) begin
        r_cnt <= '0;
        r_idx <= w_frame_wrap ? '0 : r_idx + c_idx_w'(1);
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  // Double buffer: a load at the boundary bypasses pending so it is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= '0;
      r_pend_dp <= '0;
      r_act     <= '0;
      r_act_dp  <= '0;
    end else begin
      if (load) begin
        r_pend    <= value;
        r_pend_dp <= dp_in;
      end
      if (w_frame_wrap) begin
        r_act    <= load ? value : r_pend;
        r_act_dp <= load ? dp_in : r_pend_dp;
      end
    end
  end

  // Select the current digit and decide whether it is a leading zero by
  // sweeping from the most significant digit down.
  always_comb begin
    w_nib    = 4'h0;
    w_en     = 1'b0;
    w_act_dp = 1'b0;
    w_lz     = 1'b0;
    w_an_sel = '1;
    w_run    = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_run = w_run && (r_act[4*i +: 4] == 4'h0);
      if (r_idx == c_idx_w'(i)) begin
        w_nib       = r_act[4*i +: 4];
        w_en        = digit_en[i];
        w_act_dp    = r_act_dp[i];
        w_lz        = w_run && (i != 0);
        w_an_sel[i] = 1'b0;
      end
    end
  end

  seg_font_decode u_font (
    .nib (w_nib),
    .seg (w_font)
  );

  // Registered pin drivers; a blanked leading zero keeps its anode and dp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= r_wrapped;
      if (w_in_blank || !w_en) begin
        seg <= SEG_BLANK;
        dp  <= 1'b1;
        an  <= '1;
      end else begin
        seg <= (lz_blank && w_lz) ? SEG_BLANK : w_font;
        dp  <= ~w_act_dp;
        an  <= w_an_sel;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
// ============================================================================
// Module      : tb_seven_segment_scanner
// Description : Self-checking bench for seven_segment_scanner (4 digits,
//               8-cycle slots, 2 blank cycles). Honours SEG_HEX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_segment_scanner;

  localparam int DIGITS = 4;
  localparam int RD     = 8;
  localparam int BC     = 2;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       tick;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .DIGITS       (DIGITS),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  // Reference model state
  int          m_cnt, m_idx;
  logic [15:0] m_pend, m_act;
  logic [3:0]  m_pdp, m_adp;
  logic        m_wr;
  out_t        exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_tick = -1;
  int n_ticks = 0;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
`ifdef SEG_HEX_EN
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
`else
      default: return 7'b1111111;
`endif
    endcase
  endfunction

  function automatic out_t model_out();
    out_t o;
    logic [3:0] nib;
    logic hi_zero;
    o.tick = m_wr;
    if (m_cnt < BC || !digit_en[m_idx]) begin
      o.seg = 7'b1111111;
      o.dp  = 1'b1;
      o.an  = 4'hF;
    end else begin
      nib     = m_act[m_idx*4 +: 4];
      hi_zero = ((m_act >> (4*m_idx)) == 16'h0);
      o.an    = ~(4'b0001 << m_idx);
      o.seg   = (lz_blank && m_idx != 0 && hi_zero) ? 7'b1111111 : font(nib);
      o.dp    = ~m_adp[m_idx];
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idx = 0;
    m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0;
    m_wr = 1'b0;
    exp_q.delete();
    last_tick = -1;
  endtask

  // One clock: push the expected output, advance model, pop and compare.
  task automatic step(input string tag);
    out_t e, o;
    logic wrap;
    exp_q.push_back(model_out());
    @(posedge clk);
    wrap = (m_cnt == RD - 1) && (m_idx == DIGITS - 1);
    if (load) begin
      m_pend = value;
      m_pdp  = dp_in;
    end
    if (wrap) begin
      m_act = m_pend;
      m_adp = m_pdp;
    end
    m_wr = wrap;
    if (m_cnt == RD - 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % DIGITS;
    end else begin
      m_cnt++;
    end
    #1;
    cyc++;
    e = exp_q.pop_front();
    o = {seg, dp, an, frame_tick};
    chk(tag, 32'(o), 32'(e));
    if (frame_tick) begin
      n_ticks++;
      if (last_tick >= 0) chk("tick_period", cyc - last_tick, 32);
      last_tick = cyc;
    end
  endtask

  task automatic wait_tick(input string tag);
    logic found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step(tag);
      if (frame_tick) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_tick_timeout"}, 32'(found), 32'd1);
  endtask

  task automatic wait_an(input string tag, input logic [3:0] target);
    logic found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step(tag);
      if (an == target) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_an_timeout"}, 32'(found), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_ok, n_bad, ticks0;
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = '0;
    dp_in    = '0;
    digit_en = 4'hF;
    lz_blank = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'({seg, dp, an, frame_tick}), 32'({7'b1111111, 1'b1, 4'hF, 1'b0}));

    // Idle after reset: digit 0 shows 0, frame_tick every 32 cycles
    rst_n = 1'b1;
    model_reset();
    ticks0 = n_ticks;
    for (int k = 0; k < 70; k++) step("idle");
    chk("idle_tick_count", n_ticks - ticks0, 2);

    // Mid-frame load: current frame unchanged, next frame shows 1234
    load = 1'b1; value = 16'h1234; dp_in = 4'b0100;
    step("load_mid");
    load = 1'b0;
    wait_tick("load_mid_wait");
    n_ok = 0; n_bad = 0;
    for (int k = 0; k < 32; k++) begin
      step("show_1234");
      if (dp == 1'b0 && an == 4'b1011) n_ok++;
      if (dp == 1'b0 && an != 4'b1011) n_bad++;
    end
    chk("dp_only_digit2", n_bad, 0);
    chk("dp_digit2_lit", n_ok, RD - BC);

    // Load held for several cycles, last wins; leading-zero blanking on
    lz_blank = 1'b1;
    load = 1'b1; value = 16'h9999; dp_in = 4'b0000;
    step("load_hold");
    value = 16'h0050;
    step("load_hold");
    load = 1'b0;
    wait_tick("lz_wait");
    n_ok = 0; n_bad = 0;
    for (int k = 0; k < 32; k++) begin
      step("lz_0050");
      if (an == 4'b0111 || an == 4'b1011) begin
        if (seg == 7'b1111111) n_ok++; else n_bad++;
      end
    end
    chk("lz_blanked_count", n_ok, 2 * (RD - BC));
    chk("lz_blank_errors", n_bad, 0);

    // Digit enable: digits 1 and 3 never driven, period unchanged
    lz_blank = 1'b0;
    digit_en = 4'b0101;
    n_bad = 0;
    for (int k = 0; k < 64; k++) begin
      step("digit_en");
      if (an == 4'b1101 || an == 4'b0111) n_bad++;
    end
    chk("disabled_anodes", n_bad, 0);
    digit_en = 4'hF;

    // Hex nibble and its effect on leading-zero detection
    lz_blank = 1'b1;
    load = 1'b1; value = 16'h0A00;
    step("load_hex");
    load = 1'b0;
    wait_tick("hex_wait");
    wait_an("hex_digit2", 4'b1011);
    chk("hex_A_glyph", 32'(seg), 32'(font(4'hA)));
    wait_an("hex_digit1", 4'b1101);
    chk("digit1_below_A", 32'(seg), 32'(7'b1000000));
    lz_blank = 1'b0;

    // Asynchronous reset while digit 2 is lit
    load = 1'b1; value = 16'h1234; dp_in = 4'b0000;
    step("reload");
    load = 1'b0;
    wait_tick("rst_wait");
    wait_an("rst_digit2", 4'b1011);
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", 32'(an), 32'hF);
    chk("async_rst_seg", 32'(seg), 32'h7F);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 31; k++) step("after_rst");
    load = 1'b1; value = 16'h5678; dp_in = 4'b0001;
    step("load_boundary");
    load = 1'b0;
    step("boundary_blank");
    step("boundary_blank");
    step("boundary_digit0");
    chk("boundary_an", 32'(an), 32'hE);
    chk("boundary_seg8", 32'(seg), 32'(7'b0000000));
    chk("boundary_dp", 32'(dp), 32'd0);
    for (int k = 0; k < 40; k++) step("tail");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed driver for a common-anode multi-digit seven-segment display. It holds a DIGITS-wide hex/BCD value in a double-buffered register and scans one digit at a time at a programmable refresh rate. It also provides per-digit enable, decimal points, leading-zero blanking and an anti-ghosting blank interval. It sits between the datapath (value producer) and the board pins, replacing the single-digit combinational decoder.

## Interface
Parameters:
- DIGITS, 4 — number of digits, 1..8
- REFRESH_DIV, 100000 — clock cycles per digit slot; must be ≥ BLANK_CYCLES+1
- BLANK_CYCLES, 2 — cycles at slot start with all anodes off; may be 0

Ports:
- clk  in  1  — single clock
- rst_n  in  1  — asynchronous, active-low reset
- load  in  1  — capture `value`/`dp_in` this cycle
- value  in  4*DIGITS  — nibble i drives digit i; digit 0 is rightmost
- dp_in  in  DIGITS  — bit i = 1 lights the decimal point of digit i
- digit_en  in  DIGITS  — bit i = 0 keeps digit i dark; sampled live
- lz_blank  in  1  — 1 blanks leading zeros; sampled live
- seg  out  7  — segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  — decimal point, active-low
- an  out  DIGITS  — anodes, active-low, at most one low
- frame_tick  out  1  — one-cycle pulse per completed frame

## Operation
- State:
  - slot counter `cnt` runs 0..REFRESH_DIV-1;
  - digit index `idx` runs 0..DIGITS-1 and increments when cnt wraps;
  - `idx` wraps from DIGITS-1 to 0; this wrap is the frame boundary.
- Buffering:
  - `load` = 1 writes `value`/`dp_in` into a pending register.
  - At the frame boundary, pending is copied into the active register.
  - If `load` coincides with the boundary, the incoming `value`/`dp_in` go straight to active.
  - Without a boundary, the display never changes mid-frame (no tearing).
- Per slot, for digit `idx`:
  - if cnt < BLANK_CYCLES, or digit_en[idx] = 0: an all 1, seg = 7'b1111111, dp = 1;
  - otherwise an[idx] = 0, seg = font(active nibble), dp = ~active_dp[idx].
- Leading-zero blanking (lz_blank = 1):
  - a digit is blanked when it and every higher digit are 0;
  - digit 0 is never blanked;
  - a blanked digit has seg = 7'b1111111 but still shows its dp;
  - its anode is still driven.
- Font:
  - 0–9 use the standard active-low codes (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000, 9 = 7'b0010000);
  - 10–15 are set by Configuration.
- A disabled digit still consumes its slot; frame length is always DIGITS*REFRESH_DIV cycles.

## Timing
- Reset state:
  - seg = 7'b1111111, dp = 1, an all 1, frame_tick = 0;
  - cnt = 0, idx = 0;
  - pending and active registers = 0, dp registers = 0.
- All outputs are registered: they reflect the (cnt, idx, active) state of the previous cycle, so output latency is 1 cycle.
- Frame boundary:
  - the first cycle with idx = 0, cnt = 0 after a wrap;
  - frame_tick is high in the output cycle that corresponds to it.
- A new value loaded at any cycle appears on the pins between 2 and DIGITS*REFRESH_DIV+1 cycles later.
- Reset mid-frame:
  - all outputs go dark immediately (asynchronous);
  - after release, scanning restarts at digit 0 with active = 0, so the display shows "0", or "0000" when lz_blank = 0.
- `load` held high for several cycles: the last captured value wins.

## Configuration
- Macro `SEG_HEX_EN`:
  - defined: nibbles 10–15 render A, b, C, d, E, F (active-low 7'b0001000, 0000011, 1000110, 0100001, 0000110, 0001110);
  - undefined: nibbles 10–15 render blank (7'b1111111), i.e. BCD-only, and leading-zero detection treats them as non-zero.

## Structure
- Package `seg_pkg`:
  - active-low font constants;
  - SEG_BLANK = 7'b1111111;
  - segment-vector typedef (7 bits).
- Sub-module `seg_font_decode`: combinational nibble→segment lookup, honours `SEG_HEX_EN`, instantiated once on the muxed nibble.
- Counter, index, buffers, blanking logic and output registers stay in the top module.

## Test plan
Unless noted, all tests use DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset, then idle: an = 4'b1111 for 2 cycles, then an = 4'b1110 with seg = 7'b1000000 for 6 cycles; frame_tick pulses every 32 cycles.
- Load 16'h1234 with dp_in = 4'b0100 mid-frame: the current frame is unchanged; from the next frame, digits 0..3 show 4, 3, 2, 1, and dp = 0 only while an = 4'b1011.
- lz_blank = 1, value 16'h0050: digits 3 and 2 get seg = 7'b1111111 with anodes still pulsed; digit 1 shows 5; digit 0 shows 0.
- digit_en = 4'b0101: an never reaches 4'b1101 or 4'b0111; frame period stays 32 cycles.
- Nibble 4'hA: with `SEG_HEX_EN`, seg = 7'b0001000; without it, seg = 7'b1111111.
- Assert rst_n low while an = 4'b1011:
  - an = 4'b1111 in the same cycle;
  - after release, scanning restarts at digit 0 showing 0;
  - a `load` coinciding with the boundary is visible in the same frame.
